// File: rtl/seg_capture.sv
// Purpose: rebuilds the four hex digits of a multiplexed 7-segment bus and flags bad bus states.
// Latency: a pin change reaches gdc_out/dvalid STABLE_CYC+1 cycles later. frame_valid comes on that same edge.
// Backpressure: none. The bus is sampled every cycle and pulses are not held.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-low reset
//   sal[6:0]     segments {g,f,e,d,c,b,a}, active low
//   an[3:0]      digit anodes, active low; an[0] is the rightmost digit
//   gdc_out[15:0] captured digits; nibble i is the digit shown on an[i]
//   dvalid[3:0]  dvalid[i]=1 when nibble i holds a decoded glyph
//   frame_valid  1-cycle pulse when all four digits have been seen since the last pulse
//   an_err       1-cycle pulse when a stable anode pattern has more than one digit enabled
//   glyph_err    1-cycle pulse when a stable segment pattern is neither a glyph nor blank
//   timeout      level; no capture for 2^TIMEOUT_W cycles. The next capture clears it.
module seg_capture #(
  parameter int STABLE_CYC = 4,
  parameter int TIMEOUT_W  = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  sal,
  input  logic [3:0]  an,
  output logic [15:0] gdc_out,
  output logic [3:0]  dvalid,
  output logic        frame_valid,
  output logic        an_err,
  output logic        glyph_err,
  output logic        timeout
);

  localparam int SW = $clog2(STABLE_CYC + 1);

  logic [10:0]          r_in;
  logic [10:0]          r_in_d;
  logic [SW-1:0]        r_stab;
  logic [3:0]           r_seen;
  logic [TIMEOUT_W-1:0] r_to;
  logic [15:0]          r_gdc;
  logic [3:0]           r_dvalid;
  logic                 r_frame;
  logic                 r_an_err;
  logic                 r_glyph_err;
  logic                 r_timeout;

  logic       w_same;
  logic       w_cap;
  logic       w_qual;
  logic [3:0] w_an;
  logic [6:0] w_seg;
  logic       w_hit;
  logic [3:0] w_code;
  logic       w_one;
  logic [1:0] w_idx;
  logic [3:0] w_bit;
  logic       w_mark;
  logic [3:0] w_seen_set;

  assign w_same = (r_in == r_in_d);
  // The counter reaches STABLE_CYC-1 only by stepping up from STABLE_CYC-2.
  // The capture therefore fires exactly once per stable window.
  assign w_cap  = w_same && (r_stab == SW'(STABLE_CYC - 2));
  assign w_an   = r_in[10:7];
  assign w_seg  = ~r_in[6:0];
  assign w_qual = w_cap && (w_an != 4'hF);

  always_comb begin
    w_hit  = 1'b1;
    w_code = 4'h0;
    case (w_seg)
      7'h3F: w_code = 4'h0;
      7'h06: w_code = 4'h1;
      7'h5B: w_code = 4'h2;
      7'h4F: w_code = 4'h3;
      7'h66: w_code = 4'h4;
      7'h6D: w_code = 4'h5;
      7'h7D: w_code = 4'h6;
      7'h07: w_code = 4'h7;
      7'h7F: w_code = 4'h8;
      7'h6F: w_code = 4'h9;
      7'h77: w_code = 4'hA;
      7'h7C: w_code = 4'hB;
      7'h39: w_code = 4'hC;
      7'h5E: w_code = 4'hD;
      7'h79: w_code = 4'hE;
      7'h71: w_code = 4'hF;
      default: w_hit = 1'b0;
    endcase
  end

  always_comb begin
    w_one = 1'b1;
    w_idx = 2'd0;
    case (w_an)
      4'b1110: w_idx = 2'd0;
      4'b1101: w_idx = 2'd1;
      4'b1011: w_idx = 2'd2;
      4'b0111: w_idx = 2'd3;
      default: w_one = 1'b0;
    endcase
  end

  assign w_bit      = ~w_an;
  // A digit counts as seen when it shows a real glyph or is deliberately blanked.
  assign w_mark     = w_qual && w_one && (w_hit || (w_seg == 7'h00));
  assign w_seen_set = r_seen | w_bit;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_in        <= '0;
      r_in_d      <= '0;
      r_stab      <= '0;
      r_seen      <= '0;
      r_to        <= '0;
      r_gdc       <= '0;
      r_dvalid    <= '0;
      r_frame     <= 1'b0;
      r_an_err    <= 1'b0;
      r_glyph_err <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_in        <= {an, sal};
      r_in_d      <= r_in;
      r_frame     <= 1'b0;
      r_an_err    <= 1'b0;
      r_glyph_err <= 1'b0;

      if (!w_same)
        r_stab <= '0;
      else if (r_stab != SW'(STABLE_CYC))
        r_stab <= r_stab + 1'b1;

      // A qualifying capture takes priority over the timeout terminal count.
      if (w_qual) begin
        r_to      <= '0;
        r_timeout <= 1'b0;
        if (w_one) begin
          if (w_hit) begin
            r_gdc[{w_idx, 2'b00} +: 4] <= w_code;
            r_dvalid[w_idx]            <= 1'b1;
          end else begin
            r_dvalid[w_idx] <= 1'b0;
            if (w_seg != 7'h00)
              r_glyph_err <= 1'b1;
          end
          if (w_mark) begin
            if (w_seen_set == 4'hF) begin
              r_seen  <= '0;
              r_frame <= 1'b1;
            end else begin
              r_seen <= w_seen_set;
            end
          end
        end else begin
          r_an_err <= 1'b1;
        end
      end else if (&r_to) begin
        r_timeout <= 1'b1;
        r_dvalid  <= '0;
        r_seen    <= '0;
      end else begin
        r_to <= r_to + 1'b1;
      end
    end
  end

  assign gdc_out     = r_gdc;
  assign dvalid      = r_dvalid;
  assign frame_valid = r_frame;
  assign an_err      = r_an_err;
  assign glyph_err   = r_glyph_err;
  assign timeout     = r_timeout;

endmodule
